// File: rtl/alu_seq.sv
// Multi-cycle unsigned MUL/DIV/MOD sequencer driving an external combinational alu.
// Latency: W RUN cycles after accept (error in 1). Holds rsp until rsp_ready; cmd_ready only in IDLE.
module alu_seq #(
   parameter int             W       = 8,
   parameter logic [W-1:0]   ERR_VAL = 8'hFF,
   parameter logic [4:0]     OP_ADD  = 5'd0,
   parameter logic [4:0]     OP_SUB  = 5'd1
) (
   input  logic         Clk,
   input  logic         Reset_n,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [1:0]   cmd_op,
   input  logic [W-1:0] cmd_a,
   input  logic [W-1:0] cmd_b,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [W-1:0] rsp_data,
   output logic         rsp_err,
   output logic [W-1:0] alu_a,
   output logic [W-1:0] alu_b,
   output logic [4:0]   alu_op,
   input  logic [W-1:0] alu_out
);

   localparam int CW = (W > 1) ? $clog2(W) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [1:0]     op_q, op_d;
   logic [W-1:0]   acc_q, acc_d;
   logic [W-1:0]   mcand_q, mcand_d;
   logic [W-1:0]   mplier_q, mplier_d;
   logic [W-1:0]   rem_q, rem_d;
   logic [W-1:0]   q_q, q_d;
   logic [W-1:0]   divisor_q, divisor_d;
   logic [W-1:0]   rsp_data_q, rsp_data_d;
   logic           rsp_err_q, rsp_err_d;

   // Restoring-division step: shifted partial remainder and its W+1 bit compare.
   logic [W:0]     div_t;
   logic           div_ge;
   logic [W-1:0]   mul_acc_nxt, div_rem_nxt, div_q_nxt;

   assign div_t       = {rem_q, q_q[W-1]};
   assign div_ge      = (div_t >= {1'b0, divisor_q});
   assign mul_acc_nxt = mplier_q[0] ? alu_out : acc_q;
   assign div_rem_nxt = div_ge ? alu_out : div_t[W-1:0];
   assign div_q_nxt   = {q_q[W-2:0], div_ge};

   assign cmd_ready = (state_q == IDLE);
   assign rsp_valid = (state_q == DONE);
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      op_d       = op_q;
      acc_d      = acc_q;
      mcand_d    = mcand_q;
      mplier_d   = mplier_q;
      rem_d      = rem_q;
      q_d        = q_q;
      divisor_d  = divisor_q;
      rsp_data_d = rsp_data_q;
      rsp_err_d  = rsp_err_q;
      alu_a      = '0;
      alu_b      = '0;
      alu_op     = OP_ADD;

      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               op_d      = cmd_op;
               cnt_d     = '0;
               acc_d     = '0;
               mcand_d   = cmd_a;
               mplier_d  = cmd_b;
               rem_d     = '0;
               q_d       = cmd_a;
               divisor_d = cmd_b;
               if (cmd_op == 2'b11 || (cmd_op != 2'b00 && cmd_b == '0)) begin
                  state_d    = DONE;
                  rsp_data_d = ERR_VAL;
                  rsp_err_d  = 1'b1;
               end else begin
                  state_d   = RUN;
                  rsp_err_d = 1'b0;
               end
            end
         end
         RUN: begin
            cnt_d = cnt_q + 1'b1;
            if (op_q == 2'b00) begin
               alu_a    = acc_q;
               alu_b    = mcand_q;
               alu_op   = OP_ADD;
               acc_d    = mul_acc_nxt;
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_q >> 1;
            end else begin
               alu_a  = div_t[W-1:0];
               alu_b  = divisor_q;
               alu_op = OP_SUB;
               rem_d  = div_rem_nxt;
               q_d    = div_q_nxt;
            end
            if (cnt_q == CNT_LAST) begin
               state_d = DONE;
               cnt_d   = '0;
               case (op_q)
                  2'b00:   rsp_data_d = mul_acc_nxt;
                  2'b01:   rsp_data_d = div_q_nxt;
                  default: rsp_data_d = div_rem_nxt;
               endcase
            end
         end
         DONE: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         op_q       <= 2'b00;
         acc_q      <= '0;
         mcand_q    <= '0;
         mplier_q   <= '0;
         rem_q      <= '0;
         q_q        <= '0;
         divisor_q  <= '0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         op_q       <= op_d;
         acc_q      <= acc_d;
         mcand_q    <= mcand_d;
         mplier_q   <= mplier_d;
         rem_q      <= rem_d;
         q_q        <= q_d;
         divisor_q  <= divisor_d;
         rsp_data_q <= rsp_data_d;
         rsp_err_q  <= rsp_err_d;
      end
   end

endmodule
